sd_fifo_rr_sched: RTL

- Round-robin scheduler that drains up to `inputs` FIFO tail interfaces (srdy/drdy/data) into one shared consumer.
- A per-grant burst limit bounds how many consecutive words one source may send before rotation.
- Output is a single registered srdy/drdy stage, so p_srdy and p_data come from flops.
- Sits between a bank of per-queue FIFOs and a shared downstream resource, e.g. an egress port or a shared memory write port.

---
 rtl/sd_fifo_rr_sched_pkg.sv | 9 +
 rtl/sd_rr_pick.sv | 29 ++
 rtl/sd_fifo_rr_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sd_fifo_rr_sched_pkg.sv
// Shared helpers for the sd_fifo_rr_sched round-robin FIFO drain scheduler.
package sd_fifo_rr_sched_pkg;

  // Index width for n items; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Rotating-priority encoder: first requester after cur, wrapping, cur last.
module sd_rr_pick
  import sd_fifo_rr_sched_pkg::*;
#(
  parameter  int unsigned inputs = 4,
  localparam int unsigned asz    = idx_w(inputs)
) (
  input  logic [inputs-1:0] req,
  input  logic [asz-1:0]    cur,
  output logic [asz-1:0]    sel,
  output logic              sel_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_valid = 1'b0;
    for (int k = 1; k <= int'(inputs); k++) begin
      idx = int'(cur) + k;
      if (idx >= int'(inputs)) idx = idx - int'(inputs);
      if (!sel_valid && req[asz'(idx)]) begin
        sel       = asz'(idx);
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_fifo_rr_sched.sv
// Round-robin drain of several FIFO tails into one registered output stage.
// Define SD_FIFO_RR_SCHED_PKTLOCK_EN to hold the grant until end-of-packet.
module sd_fifo_rr_sched
  import sd_fifo_rr_sched_pkg::*;
#(
  parameter  int unsigned width  = 8,
  parameter  int unsigned inputs = 4,
  parameter  int unsigned burst  = 4,
  localparam int unsigned asz    = idx_w(inputs),
  localparam int unsigned csz    = idx_w(burst + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [asz-1:0]          p_grant
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
  ,
  input  logic [inputs-1:0]       c_eop,
  output logic                    p_eop
`endif
);

  localparam logic [csz-1:0] burst_c = csz'(burst);

  logic             p_srdy_q, p_srdy_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic [asz-1:0]   p_grant_q, p_grant_d;
  logic [asz-1:0]   cur_q, cur_d;
  logic [csz-1:0]   cnt_q, cnt_d;
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
  logic             lock_q, lock_d;
  logic             p_eop_q, p_eop_d;
`endif

  logic             ld_c, hold_c, sel_valid_c, xfer_c;
  logic [asz-1:0]   sel_c;
  logic [asz-1:0]   pick_sel;
  logic             pick_valid;

  sd_rr_pick #(.inputs(inputs)) u_pick (
    .req       (c_srdy),
    .cur       (cur_q),
    .sel       (pick_sel),
    .sel_valid (pick_valid)
  );

  // Grant selection, handshake and next-state for the output stage.
  always_comb begin
    ld_c        = !p_srdy_q || p_drdy;
    hold_c      = (cnt_q != '0) && (cnt_q < burst_c) && c_srdy[cur_q];
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
    hold_c      = hold_c || lock_q;
`endif
    sel_c       = hold_c ? cur_q : pick_sel;
    sel_valid_c = hold_c ? c_srdy[cur_q] : pick_valid;
    xfer_c      = ld_c && sel_valid_c && !reset;

    c_drdy      = '0;
    p_srdy_d    = p_srdy_q;
    p_data_d    = p_data_q;
    p_grant_d   = p_grant_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
    lock_d      = lock_q;
    p_eop_d     = p_eop_q;
`endif

    if (xfer_c) c_drdy[sel_c] = 1'b1;

    if (ld_c) begin
      if (sel_valid_c) begin
        p_srdy_d  = 1'b1;
        p_data_d  = c_data[sel_c*width +: width];
        p_grant_d = sel_c;
        cur_d     = sel_c;
        // Saturate so a locked packet longer than burst cannot wrap cnt.
        if (hold_c) cnt_d = (cnt_q == burst_c) ? cnt_q : cnt_q + csz'(1);
        else        cnt_d = csz'(1);
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
        lock_d    = !c_eop[sel_c];
        p_eop_d   = c_eop[sel_c];
`endif
      end else begin
        p_srdy_d  = 1'b0;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy_q  <= 1'b0;
      p_data_q  <= '0;
      p_grant_q <= '0;
      cur_q     <= asz'(inputs - 1);
      cnt_q     <= '0;
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
      lock_q    <= 1'b0;
      p_eop_q   <= 1'b0;
`endif
    end else begin
      p_srdy_q  <= p_srdy_d;
      p_data_q  <= p_data_d;
      p_grant_q <= p_grant_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
      lock_q    <= lock_d;
      p_eop_q   <= p_eop_d;
`endif
    end
  end

  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;
  assign p_grant = p_grant_q;
`ifdef SD_FIFO_RR_SCHED_PKTLOCK_EN
  assign p_eop   = p_eop_q;
`endif

endmodule
